// File: rtl/enum_byte_decoder_pkg.sv
// Shared types for the enum byte decoder.
// Code space: ONE/TWO/THREE carried as raw bytes.
package pkg;

  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } enum_t;

  typedef enum_t  alias_t;
  typedef alias_t third_alias_t;

  typedef struct packed {
    logic [7:0] x;
  } struct_t;

  localparam third_alias_t ENUM_CODE_MAX = THREE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/enum_byte_decoder_if.sv
// Valid/ready streams of the enum byte decoder.
// Input carries raw codes, output typed values.
interface enum_byte_decoder_if;
  import pkg::*;

  logic    in_valid;
  logic    in_ready;
  struct_t in_data;
  logic    out_valid;
  logic    out_ready;
  alias_t  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/enum_byte_decoder_fifo2.sv
// Two-entry FIFO of decoded enum values.
// Head is a register so rdata is glitch-free.
module enum_dec_fifo2
  import pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  alias_t wdata,
  input  logic   pop,
  output alias_t rdata,
  output logic   full,
  output logic   empty
);

  fifo_state_t state, state_nx;
  alias_t      head, tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = HALF;
      HALF: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL: if (pop) state_nx = HALF;
      default: state_nx = EMPTY;
    endcase
  end

  // Entries shift toward head on pop from FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= ONE;
      tail <= ONE;
    end else begin
      unique case (state)
        EMPTY: if (push) head <= wdata;
        HALF: begin
          if (push && pop) head <= wdata;
          else if (push)   tail <= wdata;
        end
        FULL: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign rdata = head;
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

endmodule

// File: rtl/enum_byte_decoder.sv
// Validates raw bytes against enum_t; invalid codes flagged.
// ENUM_BYTE_DECODER_ERR_CNT_EN enables the err_count register.
module enum_byte_decoder
  import pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  enum_byte_decoder_if.slave   bus,
  output logic                 err_pulse,
  output logic                 err_seen,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic accept, code_ok, push, pop, bad;
  logic full, empty;

  assign accept  = bus.in_valid && bus.in_ready;
  assign code_ok = (bus.in_data.x <= ENUM_CODE_MAX);
  assign push    = accept && code_ok;
  assign bad     = accept && !code_ok;
  assign pop     = bus.out_valid && bus.out_ready;

  enum_dec_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (alias_t'(bus.in_data.x)),
    .pop   (pop),
    .rdata (bus.out_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (bad)          err_seen <= 1'b1;
      else if (err_clr) err_seen <= 1'b0;
    end
  end

`ifdef ENUM_BYTE_DECODER_ERR_CNT_EN
  // Clear wins first, then the same-cycle error counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= bad ? ERR_CNT_W'(1) : '0;
    end else if (bad && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_enum_byte_decoder.sv
// Scoreboard bench for enum_byte_decoder.
// Directed vectors; monitor pops expected values.
module tb_enum_byte_decoder;
  import pkg::*;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       err_pulse, err_seen, err_clr;
  logic [7:0] err_count;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t_acc, t_rel;
  alias_t     q[$];

`ifdef ENUM_BYTE_DECODER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  enum_byte_decoder_if bus ();

  enum_byte_decoder #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_pulse (err_pulse),
    .err_seen  (err_seen),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  // Monitor: every output transfer pops one expected value.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected actual=%0d required=none",
                 bus.out_data);
      end else begin
        alias_t e;
        e = q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL out_data actual=%0d required=%0d",
                   bus.out_data, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = '{x: c};
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (c <= 8'd2) q.push_back(alias_t'(c));
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 0;
    bus.in_data   = '{x: 8'd0};
    bus.out_ready = 0;
    err_clr       = 0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, ONE);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_seen", err_seen, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1;
    step(2);

    // Latency 1
    bus.out_ready = 1;
    send(8'd1);
    @(negedge clk);
    chk("lat_out_valid", bus.out_valid, 1);
    chk("lat_out_data", bus.out_data, TWO);
    chk("lat_err_pulse", err_pulse, 0);
    step(1);

    // Backpressure
    bus.out_ready = 0;
    send(8'd0);
    send(8'd2);
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    step(1);
    fork
      begin
        send(8'd1);
        t_acc = cyc;
      end
      begin
        step(3);
        t_rel = cyc;
        bus.out_ready = 1;
      end
    join
    chk("third_after_pop", t_acc - t_rel, 2);
    step(4);
    chk("drain_q", q.size(), 0);

    // Invalid codes
    send(8'h03);
    @(negedge clk);
    chk("inv1_pulse", err_pulse, 1);
    send(8'hFF);
    @(negedge clk);
    chk("inv2_pulse", err_pulse, 1);
    chk("inv_seen", err_seen, 1);
    chk("inv_count", err_count, CNT_EN ? 2 : 0);
    step(1);
    @(negedge clk);
    chk("pulse_drop", err_pulse, 0);
    step(1);

    // Saturation
    err_clr = 1;
    step(1);
    err_clr = 0;
    @(negedge clk);
    chk("clr_seen", err_seen, 0);
    step(1);
    for (int i = 0; i < 255; i++) send(8'd3 + 8'(i % 200));
    @(negedge clk);
    chk("cnt_255", err_count, CNT_EN ? 255 : 0);
    send(8'h80);
    @(negedge clk);
    chk("cnt_sat", err_count, CNT_EN ? 255 : 0);
    step(1);
    err_clr = 1;
    send(8'd7);
    err_clr = 0;
    @(negedge clk);
    chk("clr_and_err", err_count, CNT_EN ? 1 : 0);
    chk("clr_and_seen", err_seen, 1);
    step(1);

    // Async reset while FULL
    bus.out_ready = 0;
    send(8'd2);
    send(8'd0);
    #2;
    chk("pre_rst_full", bus.in_ready, 0);
    rst_n = 0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_err_count", err_count, 0);
    chk("arst_err_seen", err_seen, 0);
    q.delete();
    step(2);
    rst_n = 1;
    step(1);
    bus.out_ready = 1;
    send(8'd2);
    step(3);
    chk("post_rst_q", q.size(), 0);

    // Five invalid codes
    for (int i = 0; i < 5; i++) send(8'd10 + 8'(i));
    @(negedge clk);
    chk("five_count", err_count, CNT_EN ? 5 : 0);
    chk("five_seen", err_seen, 1);
    step(3);
    chk("final_q", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1);
  end

endmodule
